vdp_host_port: RTL

Parametrised host-bus front end for the VDP core. It sits between the asynchronous CPU strobes (csr_n/csw_n, mode, cd) and the VDP REQ/ACK/WRT/ADR/DBO/DBI port, replacing the ad-hoc two-flop sync and single io_state flag.
- Adds configurable synchroniser depth, a glitch filter, a real REQ/ACK handshake with timeout, a read-data hold latch with output enable, and error/timeout counters.

---
 rtl/vdp_host_port.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vdp_host_port.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vdp_host_port
// Host-bus front end for the VDP core. Synchronises and de-glitches the
// asynchronous CPU read/write strobes, runs a REQ/ACK handshake towards the
// VDP with an acknowledge timeout, holds read data for the host pins, and
// counts protocol errors (both strobes low) and timed-out accesses.
//
// Ports
//   clk, reset          VDP clock, asynchronous active-high reset
//   csr_n, csw_n        async host read/write strobes (active low)
//   mode                host port select, sampled at access start
//   host_din            host data pins (write data)
//   host_dout, host_oe  read data to pins and its drive enable
//   vdp_req/wrt/adr/dbo request, direction, port select, write data to core
//   vdp_dbi, vdp_ack    read data and single-cycle acknowledge from core
//   busy                FSM not idle
//   err_cnt, tmo_cnt    saturating error / timeout counters
// ---------------------------------------------------------------------------
module vdp_host_port #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2,
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 8,
    parameter int BIT_REVERSE = 1,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_n,
    input  logic              csw_n,
    input  logic [ADDR_W-1:0] mode,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              host_oe,
    output logic              vdp_req,
    output logic              vdp_wrt,
    output logic [ADDR_W-1:0] vdp_adr,
    output logic [DATA_W-1:0] vdp_dbo,
    input  logic [DATA_W-1:0] vdp_dbi,
    input  logic              vdp_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  tmo_cnt
);

    // Run counter only needs to reach FILTER_LEN-1.
    localparam int RUN_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W; k++) begin
            r[k] = v[DATA_W-1-k];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v != {CNT_W{1'b1}}) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Index 0 = read strobe, index 1 = write strobe.
    logic [1:0]                  strb_pin_s;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][RUN_W-1:0]       run_q, run_d;
    logic [1:0]                  filt_q, filt_d;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           adr_q, adr_d;
    logic [DATA_W-1:0]           dbo_q, dbo_d;
    logic                        wrt_q, wrt_d;
    logic                        req_q, req_d;
    logic                        rd_acc_q, rd_acc_d;
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic [DATA_W-1:0]           latch_q, latch_d;
    logic [CNT_W-1:0]            err_q, err_d;
    logic [CNT_W-1:0]            tcnt_q, tcnt_d;
    logic                        oe_q, oe_d;
    logic                        busy_q, busy_d;

    assign strb_pin_s = {csw_n, csr_n};

    // Synchroniser shift and glitch filter next-state.
    // The filtered level flips once FILTER_LEN consecutive synchronised
    // samples disagree with it; counted from the first sampling edge the
    // pin-to-filtered latency is SYNC_STAGES+FILTER_LEN-1 cycles.
    always_comb begin
        sync_d = sync_q;
        run_d  = run_q;
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], strb_pin_s[i]};
            if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
                run_d[i]  = {RUN_W{1'b0}};
                filt_d[i] = filt_q[i];
            end else if (run_q[i] == RUN_W'(FILTER_LEN - 1)) begin
                run_d[i]  = {RUN_W{1'b0}};
                filt_d[i] = sync_q[i][SYNC_STAGES-1];
            end else begin
                run_d[i]  = run_q[i] + {{(RUN_W-1){1'b0}}, 1'b1};
                filt_d[i] = filt_q[i];
            end
        end
    end

    // Access FSM next-state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dbo_d    = dbo_q;
        wrt_d    = wrt_q;
        req_d    = req_q;
        rd_acc_d = rd_acc_q;
        tmr_d    = tmr_q;
        latch_d  = latch_q;
        err_d    = err_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (!filt_q[0] && !filt_q[1]) begin
                    err_d    = sat_inc(err_q);
                    rd_acc_d = 1'b0;
                    state_d  = S_RELEASE;
                end else if (!filt_q[0] || !filt_q[1]) begin
                    adr_d    = mode;
                    dbo_d    = (BIT_REVERSE != 0) ? bit_rev(host_din) : host_din;
                    wrt_d    = !filt_q[1];
                    rd_acc_d = !filt_q[0];
                    req_d    = 1'b1;
                    tmr_d    = TMR_W'(ACK_TIMEOUT);
                    state_d  = S_REQ;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_REQ: begin
                // Ack is checked first so it wins over the last timeout cycle.
                if (vdp_ack) begin
                    req_d   = 1'b0;
                    wrt_d   = 1'b0;
                    state_d = S_RELEASE;
                    if (rd_acc_q) begin
                        latch_d = vdp_dbi;
                    end else begin
                        latch_d = latch_q;
                    end
                end else if (tmr_q == {{(TMR_W-1){1'b0}}, 1'b1}) begin
                    req_d   = 1'b0;
                    wrt_d   = 1'b0;
                    tcnt_d  = sat_inc(tcnt_q);
                    state_d = S_RELEASE;
                end else begin
                    tmr_d   = tmr_q - {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            S_RELEASE: begin
                // Both strobes must go high before another access can start.
                if (filt_q == 2'b11) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                wrt_d   = 1'b0;
            end
        endcase
        oe_d   = (state_d == S_RELEASE) && rd_acc_d && !filt_d[0];
        busy_d = (state_d != S_IDLE);
    end

    // Synchroniser and filter registers; strobes reset to their idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {2{ {SYNC_STAGES{1'b1}} }};
            run_q  <= {2{ {RUN_W{1'b0}} }};
            filt_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
            filt_q <= filt_d;
        end
    end

    // FSM state, handshake outputs, read latch and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            adr_q    <= {ADDR_W{1'b0}};
            dbo_q    <= {DATA_W{1'b0}};
            wrt_q    <= 1'b0;
            req_q    <= 1'b0;
            rd_acc_q <= 1'b0;
            tmr_q    <= {TMR_W{1'b0}};
            latch_q  <= {DATA_W{1'b0}};
            err_q    <= {CNT_W{1'b0}};
            tcnt_q   <= {CNT_W{1'b0}};
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dbo_q    <= dbo_d;
            wrt_q    <= wrt_d;
            req_q    <= req_d;
            rd_acc_q <= rd_acc_d;
            tmr_q    <= tmr_d;
            latch_q  <= latch_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
        end
    end

    // Bit reversal of the held read data is pure wiring.
    assign host_dout = (BIT_REVERSE != 0) ? bit_rev(latch_q) : latch_q;
    assign host_oe   = oe_q;
    assign vdp_req   = req_q;
    assign vdp_wrt   = wrt_q;
    assign vdp_adr   = adr_q;
    assign vdp_dbo   = dbo_q;
    assign busy      = busy_q;
    assign err_cnt   = err_q;
    assign tmo_cnt   = tcnt_q;

endmodule
